mem_wb_reg: RTL and testbench

- MEM→WB pipeline register of the 5-stage MIPS-style core.
- Captures the memory-stage results (load data, ALU result), destination register indices and writeback control fields on the clock edge.
- Presents them to the writeback stage.
- Supports stall (enable low), synchronous flush and asynchronous clear.

---
 rtl/mem_wb_reg_pkg.sv | 33 +++
 rtl/mem_wb_reg_if.sv | 52 +++++
 rtl/mem_wb_reg_field.sv | 35 +++
 rtl/mem_wb_reg.sv | 55 +++++
 tb/tb_mem_wb_reg.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_reg_pkg.sv
// Shared widths, instruction-class codes and the MEM->WB record layout.
// MEM_WB_PC_TRACE_EN adds the retiring-instruction PC to the record.
package mem_wb_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned REG_AW_DEF  = 5;
    localparam int unsigned ITYPE_W_DEF = 3;

    typedef enum logic [ITYPE_W_DEF-1:0] {
        NONE   = 3'd0,
        RTYPE  = 3'd1,
        ITYPE  = 3'd2,
        LOAD   = 3'd3,
        STORE  = 3'd4,
        BRANCH = 3'd5,
        JUMP   = 3'd6
    } itype_e;

    typedef struct packed {
        logic                   valid;
`ifdef MEM_WB_PC_TRACE_EN
        logic [DATA_W_DEF-1:0]  pc;
`endif
        logic [REG_AW_DEF-1:0]  rd;
        logic [REG_AW_DEF-1:0]  rt;
        logic [DATA_W_DEF-1:0]  mem_rd;
        logic [DATA_W_DEF-1:0]  alu_result;
        logic                   mem_to_reg;
        logic                   reg_src;
        itype_e                 instr_type;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg_if.sv
// MEM->WB bundle: upstream d_* fields and control in, registered q_* fields out.
// MEM_WB_PC_TRACE_EN adds d_pc/q_pc.
interface mem_wb_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned ITYPE_W = 3
);
    logic               en;
    logic               flush;
    logic [REG_AW-1:0]  d_rd;
    logic [REG_AW-1:0]  d_rt;
    logic [DATA_W-1:0]  d_MemRd;
    logic [DATA_W-1:0]  d_ALUresult;
    logic               d_MemtoReg;
    logic               d_RegSrc;
    logic [ITYPE_W-1:0] d_InstrType;
    logic [REG_AW-1:0]  q_rd;
    logic [REG_AW-1:0]  q_rt;
    logic [DATA_W-1:0]  q_MemRd;
    logic [DATA_W-1:0]  q_ALUresult;
    logic               q_MemtoReg;
    logic               q_RegSrc;
    logic [ITYPE_W-1:0] q_InstrType;
    logic               q_valid;
`ifdef MEM_WB_PC_TRACE_EN
    logic [DATA_W-1:0]  d_pc;
    logic [DATA_W-1:0]  q_pc;
`endif

    modport master (
        output en, flush, d_rd, d_rt, d_MemRd, d_ALUresult,
               d_MemtoReg, d_RegSrc, d_InstrType,
`ifdef MEM_WB_PC_TRACE_EN
        output d_pc,
        input  q_pc,
`endif
        input  q_rd, q_rt, q_MemRd, q_ALUresult,
               q_MemtoReg, q_RegSrc, q_InstrType, q_valid
    );

    modport slave (
        input  en, flush, d_rd, d_rt, d_MemRd, d_ALUresult,
               d_MemtoReg, d_RegSrc, d_InstrType,
`ifdef MEM_WB_PC_TRACE_EN
        input  d_pc,
        output q_pc,
`endif
        output q_rd, q_rt, q_MemRd, q_ALUresult,
               q_MemtoReg, q_RegSrc, q_InstrType, q_valid
    );

endinterface

// File: rtl/mem_wb_reg_field.sv
// Generic pipeline field register: async active-low clear, sync flush, load enable.
module pipe_field_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] field_d;
    logic [WIDTH-1:0] field_q;

    // flush outranks enable; neither asserted holds the stage
    always_comb begin
        field_d = field_q;
        if (flush_i) begin
            field_d = '0;
        end else if (en_i) begin
            field_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            field_q <= '0;
        end else begin
            field_q <= field_d;
        end
    end

    assign q_o = field_q;

endmodule

// File: rtl/mem_wb_reg.sv
// MEM->WB pipeline register; all fields share one stall/flush/clear register.
// MEM_WB_PC_TRACE_EN adds a registered PC for retirement trace.
module mem_wb_reg
    import mem_wb_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned REG_AW  = REG_AW_DEF,
    parameter int unsigned ITYPE_W = ITYPE_W_DEF
) (
    input  logic   clk,
    input  logic   reset,
    mem_wb_if.slave bus
);
    localparam int unsigned CORE_W = 1 + 2*REG_AW + 2*DATA_W + 2 + ITYPE_W;
`ifdef MEM_WB_PC_TRACE_EN
    localparam int unsigned STAGE_W = CORE_W + DATA_W;
`else
    localparam int unsigned STAGE_W = CORE_W;
`endif

    logic [STAGE_W-1:0] stage_d;
    logic [STAGE_W-1:0] stage_q;

    // valid enters as a constant 1 so an enabled load marks a real instruction
    // and flush/reset turn it into the all-zero bubble with the other fields
    assign stage_d = {
        1'b1,
`ifdef MEM_WB_PC_TRACE_EN
        bus.d_pc,
`endif
        bus.d_rd, bus.d_rt, bus.d_MemRd, bus.d_ALUresult,
        bus.d_MemtoReg, bus.d_RegSrc, bus.d_InstrType
    };

    pipe_field_reg #(
        .WIDTH (STAGE_W)
    ) u_stage (
        .clk_i   (clk),
        .rst_ni  (reset),
        .en_i    (bus.en),
        .flush_i (bus.flush),
        .d_i     (stage_d),
        .q_o     (stage_q)
    );

    assign {
        bus.q_valid,
`ifdef MEM_WB_PC_TRACE_EN
        bus.q_pc,
`endif
        bus.q_rd, bus.q_rt, bus.q_MemRd, bus.q_ALUresult,
        bus.q_MemtoReg, bus.q_RegSrc, bus.q_InstrType
    } = stage_q;

endmodule

// File: tb/tb_mem_wb_reg.sv
// Scoreboard bench for mem_wb_reg: directed vectors push expected records,
// a monitor process pops and compares them against the registered outputs.
module tb_mem_wb_reg;
    import mem_wb_pkg::*;

    logic clk;
    logic reset;

    mem_wb_if #(
        .DATA_W  (DATA_W_DEF),
        .REG_AW  (REG_AW_DEF),
        .ITYPE_W (ITYPE_W_DEF)
    ) bus ();

    mem_wb_reg #(
        .DATA_W  (DATA_W_DEF),
        .REG_AW  (REG_AW_DEF),
        .ITYPE_W (ITYPE_W_DEF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_wb_t exp_q[$];
    event    sample_ev;
    int      n_checks = 0;
    int      n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every queued expectation against the live outputs
    initial begin
        mem_wb_t e;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("q_valid",     32'(bus.q_valid),     32'(e.valid));
                chk("q_rd",        32'(bus.q_rd),        32'(e.rd));
                chk("q_rt",        32'(bus.q_rt),        32'(e.rt));
                chk("q_MemRd",     32'(bus.q_MemRd),     32'(e.mem_rd));
                chk("q_ALUresult", 32'(bus.q_ALUresult), 32'(e.alu_result));
                chk("q_MemtoReg",  32'(bus.q_MemtoReg),  32'(e.mem_to_reg));
                chk("q_RegSrc",    32'(bus.q_RegSrc),    32'(e.reg_src));
                chk("q_InstrType", 32'(bus.q_InstrType), 32'(e.instr_type));
`ifdef MEM_WB_PC_TRACE_EN
                chk("q_pc",        32'(bus.q_pc),        32'(e.pc));
`endif
            end
        end
    end

    task automatic expect_q(input logic [4:0] rd, input logic [4:0] rt,
                            input logic [31:0] memrd, input logic [31:0] alu,
                            input logic m2r, input logic rs, input itype_e it,
                            input logic valid, input logic [31:0] pc);
        mem_wb_t e;
        e            = '0;
        e.valid      = valid;
        e.rd         = rd;
        e.rt         = rt;
        e.mem_rd     = memrd;
        e.alu_result = alu;
        e.mem_to_reg = m2r;
        e.reg_src    = rs;
        e.instr_type = it;
`ifdef MEM_WB_PC_TRACE_EN
        e.pc         = pc;
`else
        if (pc != 32'h0) e.valid = valid;
`endif
        exp_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic drive(input logic [4:0] rd, input logic [4:0] rt,
                         input logic [31:0] memrd, input logic [31:0] alu,
                         input logic m2r, input logic rs, input itype_e it,
                         input logic [31:0] pc);
        bus.d_rd        = rd;
        bus.d_rt        = rt;
        bus.d_MemRd     = memrd;
        bus.d_ALUresult = alu;
        bus.d_MemtoReg  = m2r;
        bus.d_RegSrc    = rs;
        bus.d_InstrType = it;
`ifdef MEM_WB_PC_TRACE_EN
        bus.d_pc        = pc;
`else
        if (pc != 32'h0) bus.d_InstrType = it;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        bus.en    = 1'b1;
        bus.flush = 1'b0;
        drive(5'd2, 5'd3, 32'd5, 32'd30, 1'b1, 1'b1, RTYPE, 32'h100);

        // Reset asserted: outputs clear with no clock edge, and stay clear across one
        #2;
        expect_q(5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, NONE, 1'b0, 32'h0);
        tick();
        expect_q(5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, NONE, 1'b0, 32'h0);

        // Load on first enabled edge after release
        reset = 1'b1;
        tick();
        expect_q(5'd2, 5'd3, 32'd5, 32'd30, 1'b1, 1'b1, RTYPE, 1'b1, 32'h100);

        // Update
        drive(5'd5, 5'd6, 32'd25, 32'd230, 1'b1, 1'b1, ITYPE, 32'h104);
        tick();
        expect_q(5'd5, 5'd6, 32'd25, 32'd230, 1'b1, 1'b1, ITYPE, 1'b1, 32'h104);

        // Stall for two edges
        bus.en = 1'b0;
        drive(5'd5, 5'd6, 32'd55, 32'd35, 1'b0, 1'b0, LOAD, 32'h108);
        tick();
        expect_q(5'd5, 5'd6, 32'd25, 32'd230, 1'b1, 1'b1, ITYPE, 1'b1, 32'h104);
        tick();
        expect_q(5'd5, 5'd6, 32'd25, 32'd230, 1'b1, 1'b1, ITYPE, 1'b1, 32'h104);

        // Async reset between edges with en=1
        bus.en = 1'b1;
        reset  = 1'b0;
        #1;
        expect_q(5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, NONE, 1'b0, 32'h0);
        tick();
        expect_q(5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, NONE, 1'b0, 32'h0);
        reset = 1'b1;
        tick();
        expect_q(5'd5, 5'd6, 32'd55, 32'd35, 1'b0, 1'b0, LOAD, 1'b1, 32'h108);

        // Flush with en=0 on a loaded register, then reload
        bus.en    = 1'b0;
        bus.flush = 1'b1;
        tick();
        expect_q(5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, NONE, 1'b0, 32'h0);
        bus.flush = 1'b0;
        bus.en    = 1'b1;
        drive(5'd31, 5'd17, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, JUMP, 32'hFFFF_FFFC);
        tick();
        expect_q(5'd31, 5'd17, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, JUMP, 1'b1, 32'hFFFF_FFFC);

        // Flush outranks enable
        bus.flush = 1'b1;
        tick();
        expect_q(5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, NONE, 1'b0, 32'h0);

        // A stalled bubble stays a bubble
        bus.flush = 1'b0;
        bus.en    = 1'b0;
        tick();
        expect_q(5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, NONE, 1'b0, 32'h0);

        bus.en = 1'b1;
        drive(5'd9, 5'd10, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 1'b1, STORE, 32'h200);
        tick();
        expect_q(5'd9, 5'd10, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 1'b1, STORE, 1'b1, 32'h200);

        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
